// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Pure definitions: no latency, no backpressure.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_I,
    TAG_I_OOR,
    TAG_D,
    TAG_D_OOR
  } tag_e;

  localparam logic [31:0] BAD_INSTR = 32'hdeadbeef;
  localparam logic [3:0]  WEN_READ  = 4'b0000;

endpackage

// File: rtl/resp_tag_pipe.sv
// Read-response tag delay line: a tag entering now appears at tag_o DEPTH cycles later.
// No backpressure; async clear drops every in-flight tag.
module resp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_e tag_i,
  output tag_e tag_o
);

  tag_e stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_i;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store; grant and issue in the same cycle,
// read data returns RD_LATENCY cycles later. No response backpressure; data wins unless fetch is starved.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WORDS    = 1024,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wen,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wen,
  input  logic [31:0] m_rdata
);

  localparam int          CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] ADDR_END = 32'(4 * MEM_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]      i_rdata_q, d_rdata_q;
  logic             i_win, d_win;
  logic             i_oor, d_oor;
  tag_e             tag_push, tag_pop;

  assign i_oor = (i_addr >= ADDR_END);
  assign d_oor = (d_addr >= ADDR_END);

  // Grants are held low for the whole time reset is asserted.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (rst_n) begin
      if (i_req && d_req) begin
        if (starve_cnt_q == CNT_MAX) i_win = 1'b1;
        else                         d_win = 1'b1;
      end else begin
        i_win = i_req;
        d_win = d_req;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_win)          starve_cnt_d = '0;
    else if (starve_cnt_q != CNT_MAX) starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  // Out-of-range accesses are granted but never strobe the memory.
  always_comb begin
    m_en     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wen    = WEN_READ;
    tag_push = TAG_NONE;
    if (i_win) begin
      m_en     = !i_oor;
      m_addr   = {2'b00, i_addr[31:2]};
      tag_push = i_oor ? TAG_I_OOR : TAG_I;
    end else if (d_win) begin
      m_en    = !d_oor;
      m_addr  = {2'b00, d_addr[31:2]};
      m_wdata = d_wdata;
      m_wen   = d_oor ? WEN_READ : d_wen;
      if (d_wen == WEN_READ) tag_push = d_oor ? TAG_D_OOR : TAG_D;
    end
  end

  assign i_gnt = i_win;
  assign d_gnt = d_win;

  resp_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_push),
    .tag_o (tag_pop)
  );

  // An out-of-range load has no defined data, so the memory bus is passed through as-is.
  always_comb begin
    i_rvalid = (tag_pop == TAG_I) || (tag_pop == TAG_I_OOR);
    d_rvalid = (tag_pop == TAG_D) || (tag_pop == TAG_D_OOR);
    i_rdata  = i_rdata_q;
    d_rdata  = d_rdata_q;
    if (i_rvalid) i_rdata = (tag_pop == TAG_I_OOR) ? BAD_INSTR : m_rdata;
    if (d_rvalid) d_rdata = m_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      i_rdata_q    <= i_rdata;
      d_rdata_q    <= d_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiter instances (read latency 1 and 3) share the same request stimulus,
// each backed by its own small memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wen;

  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_en1;
  logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic [3:0]  m_wen1;
  logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, m_en3;
  logic [31:0] i_rdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;
  logic [3:0]  m_wen3;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] INSN = 32'h00500093;

  mem_port_arbiter #(.MEM_WORDS(1024), .RD_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wen(d_wen),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_en(m_en1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_wen(m_wen1), .m_rdata(m_rdata1)
  );

  mem_port_arbiter #(.MEM_WORDS(1024), .RD_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wen(d_wen),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .m_en(m_en3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_wen(m_wen3), .m_rdata(m_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: zeroed with word 2 = INSN while reset is low.
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] rp1, rp3a, rp3b, rp3c;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 1024; k++) mem1[k] <= 32'h0;
      mem1[2] <= INSN;
    end else if (m_en1) begin
      if (m_wen1 == 4'b0000) rp1 <= mem1[m_addr1[9:0]];
      else for (int b = 0; b < 4; b++)
        if (m_wen1[b]) mem1[m_addr1[9:0]][8*b +: 8] <= m_wdata1[8*b +: 8];
    end
  end
  assign m_rdata1 = rp1;

  always @(posedge clk) begin
    rp3b <= rp3a;
    rp3c <= rp3b;
    rp3a <= (rst_n && m_en3 && m_wen3 == 4'b0000) ? mem3[m_addr3[9:0]] : 32'h0;
    if (!rst_n) begin
      for (int k = 0; k < 1024; k++) mem3[k] <= 32'h0;
      mem3[2] <= INSN;
    end else if (m_en3 && m_wen3 != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (m_wen3[b]) mem3[m_addr3[9:0]][8*b +: 8] <= m_wdata3[8*b +: 8];
    end
  end
  assign m_rdata3 = rp3c;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0;
    d_req = 1'b0;
    d_wen = 4'b0000;
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_addr = 32'h10; d_wdata = 32'h0; d_wen = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (i_gnt1 !== 1'b0) begin errors++; $display("FAIL rst_i_gnt got=%b exp=0", i_gnt1); end
    checks++; if (d_gnt1 !== 1'b0) begin errors++; $display("FAIL rst_d_gnt got=%b exp=0", d_gnt1); end
    checks++; if (m_en1 !== 1'b0) begin errors++; $display("FAIL rst_m_en got=%b exp=0", m_en1); end
    checks++; if (m_wen1 !== 4'b0) begin errors++; $display("FAIL rst_m_wen got=%h exp=0", m_wen1); end
    checks++; if (i_rvalid1 !== 1'b0) begin errors++; $display("FAIL rst_i_rvalid got=%b exp=0", i_rvalid1); end
    checks++; if (d_rvalid1 !== 1'b0) begin errors++; $display("FAIL rst_d_rvalid got=%b exp=0", d_rvalid1); end
    checks++; if (i_rdata1 !== 32'h0) begin errors++; $display("FAIL rst_i_rdata got=%h exp=0", i_rdata1); end
    checks++; if (d_rdata1 !== 32'h0) begin errors++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata1); end
    checks++; if (i_gnt3 !== 1'b0 || d_gnt3 !== 1'b0) begin errors++; $display("FAIL rst_gnt3 got=%b%b exp=00", i_gnt3, d_gnt3); end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_fetch();
    i_req = 1'b1; i_addr = 32'h8;
    @(negedge clk);
    checks++; if (i_gnt1 !== 1'b1) begin errors++; $display("FAIL fetch_gnt got=%b exp=1", i_gnt1); end
    checks++; if (d_gnt1 !== 1'b0) begin errors++; $display("FAIL fetch_d_gnt got=%b exp=0", d_gnt1); end
    checks++; if (m_en1 !== 1'b1) begin errors++; $display("FAIL fetch_m_en got=%b exp=1", m_en1); end
    checks++; if (m_addr1 !== 32'h2) begin errors++; $display("FAIL fetch_m_addr got=%h exp=2", m_addr1); end
    checks++; if (m_wen1 !== 4'b0) begin errors++; $display("FAIL fetch_m_wen got=%h exp=0", m_wen1); end
    next_cycle();
    i_req = 1'b0;
    @(negedge clk);
    checks++; if (i_rvalid1 !== 1'b1) begin errors++; $display("FAIL fetch_rvalid got=%b exp=1", i_rvalid1); end
    checks++; if (i_rdata1 !== INSN) begin errors++; $display("FAIL fetch_rdata got=%h exp=%h", i_rdata1, INSN); end
    checks++; if (d_rvalid1 !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid got=%b exp=0", d_rvalid1); end
    checks++; if (i_rvalid3 !== 1'b0) begin errors++; $display("FAIL fetch_early_rvalid3 got=%b exp=0", i_rvalid3); end
    next_cycle();
    @(negedge clk);
    checks++; if (i_rvalid1 !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_once got=%b exp=0", i_rvalid1); end
    checks++; if (i_rdata1 !== INSN) begin errors++; $display("FAIL fetch_rdata_hold got=%h exp=%h", i_rdata1, INSN); end
    next_cycle();
    @(negedge clk);
    checks++; if (i_rvalid3 !== 1'b1) begin errors++; $display("FAIL fetch_rvalid3 got=%b exp=1", i_rvalid3); end
    checks++; if (i_rdata3 !== INSN) begin errors++; $display("FAIL fetch_rdata3 got=%h exp=%h", i_rdata3, INSN); end
    idle(3);
  endtask

  task automatic test_priority();
    logic exp_i, prev_i;
    prev_i = 1'b0;
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_addr = 32'h10; d_wen = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      exp_i = (k % 5 == 4);
      @(negedge clk);
      checks++; if (i_gnt1 !== exp_i || d_gnt1 !== !exp_i) begin
        errors++; $display("FAIL prio_gnt cycle %0d got i=%b d=%b exp i=%b d=%b", k, i_gnt1, d_gnt1, exp_i, !exp_i);
      end
      if (k > 0) begin
        checks++; if (i_rvalid1 !== prev_i || d_rvalid1 !== !prev_i) begin
          errors++; $display("FAIL prio_resp cycle %0d got i=%b d=%b exp i=%b d=%b", k, i_rvalid1, d_rvalid1, prev_i, !prev_i);
        end
      end
      prev_i = exp_i;
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checks++; if (i_rvalid1 !== 1'b1 || i_rdata1 !== INSN) begin
      errors++; $display("FAIL prio_last_resp got v=%b d=%h exp v=1 d=%h", i_rvalid1, i_rdata1, INSN);
    end
    idle(4);
  endtask

  task automatic test_store_load();
    d_req = 1'b1; d_wen = 4'b1111; d_addr = 32'h200; d_wdata = 32'h4;
    @(negedge clk);
    checks++; if (d_gnt1 !== 1'b1) begin errors++; $display("FAIL st_gnt got=%b exp=1", d_gnt1); end
    checks++; if (m_en1 !== 1'b1 || m_wen1 !== 4'b1111) begin errors++; $display("FAIL st_m_en_wen got=%b/%h exp=1/f", m_en1, m_wen1); end
    checks++; if (m_addr1 !== 32'h80) begin errors++; $display("FAIL st_m_addr got=%h exp=80", m_addr1); end
    checks++; if (m_wdata1 !== 32'h4) begin errors++; $display("FAIL st_m_wdata got=%h exp=4", m_wdata1); end
    next_cycle();
    d_wen = 4'b0000;
    @(negedge clk);
    checks++; if (d_gnt1 !== 1'b1 || m_en1 !== 1'b1 || m_wen1 !== 4'b0) begin
      errors++; $display("FAIL ld_issue got gnt=%b en=%b wen=%h exp 1/1/0", d_gnt1, m_en1, m_wen1);
    end
    checks++; if (d_rvalid1 !== 1'b0) begin errors++; $display("FAIL st_no_rvalid got=%b exp=0", d_rvalid1); end
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    checks++; if (d_rvalid1 !== 1'b1) begin errors++; $display("FAIL ld_rvalid got=%b exp=1", d_rvalid1); end
    checks++; if (d_rdata1 !== 32'h4) begin errors++; $display("FAIL ld_rdata got=%h exp=4", d_rdata1); end
    idle(4);
  endtask

  task automatic test_out_of_range();
    i_req = 1'b1; i_addr = 32'h1000;
    @(negedge clk);
    checks++; if (i_gnt1 !== 1'b1) begin errors++; $display("FAIL oor_i_gnt got=%b exp=1", i_gnt1); end
    checks++; if (m_en1 !== 1'b0) begin errors++; $display("FAIL oor_i_m_en got=%b exp=0", m_en1); end
    next_cycle();
    i_req = 1'b0;
    d_req = 1'b1; d_wen = 4'b1111; d_addr = 32'h1000; d_wdata = 32'h12345678;
    @(negedge clk);
    checks++; if (i_rvalid1 !== 1'b1 || i_rdata1 !== 32'hdeadbeef) begin
      errors++; $display("FAIL oor_i_resp got v=%b d=%h exp v=1 d=deadbeef", i_rvalid1, i_rdata1);
    end
    checks++; if (d_gnt1 !== 1'b1 || m_en1 !== 1'b0 || m_wen1 !== 4'b0) begin
      errors++; $display("FAIL oor_st got gnt=%b en=%b wen=%h exp 1/0/0", d_gnt1, m_en1, m_wen1);
    end
    next_cycle();
    d_wen = 4'b0000; d_addr = 32'h0;
    @(negedge clk);
    checks++; if (d_gnt1 !== 1'b1 || m_en1 !== 1'b1) begin errors++; $display("FAIL oor_ld0_issue got gnt=%b en=%b exp 1/1", d_gnt1, m_en1); end
    next_cycle();
    d_req = 1'b0;
    i_req = 1'b1; i_addr = 32'hffc;
    @(negedge clk);
    checks++; if (d_rvalid1 !== 1'b1 || d_rdata1 !== 32'h0) begin
      errors++; $display("FAIL oor_mem_unchanged got v=%b d=%h exp v=1 d=0", d_rvalid1, d_rdata1);
    end
    checks++; if (m_en1 !== 1'b1 || m_addr1 !== 32'h3ff) begin
      errors++; $display("FAIL top_word_issue got en=%b addr=%h exp 1/3ff", m_en1, m_addr1);
    end
    idle(4);
  endtask

  task automatic test_latency_sweep();
    int nrv;
    int j;
    logic exp_iv, exp_dv;
    nrv = 0;
    for (int k = 0; k < 11; k++) begin
      if (k < 8 && k % 2 == 0) begin
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b0;
      end else if (k < 8) begin
        i_req = 1'b0; d_req = 1'b1; d_addr = 32'h200; d_wen = 4'b0000;
      end else begin
        i_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk);
      if (k < 8) begin
        checks++; if ((k % 2 == 0 ? i_gnt3 : d_gnt3) !== 1'b1) begin
          errors++; $display("FAIL sweep_gnt cycle %0d got i=%b d=%b", k, i_gnt3, d_gnt3);
        end
      end
      j = k - 3;
      exp_iv = (j >= 0 && j < 8 && j % 2 == 0);
      exp_dv = (j >= 0 && j < 8 && j % 2 == 1);
      checks++; if (i_rvalid3 !== exp_iv || d_rvalid3 !== exp_dv) begin
        errors++; $display("FAIL sweep_rvalid cycle %0d got i=%b d=%b exp i=%b d=%b", k, i_rvalid3, d_rvalid3, exp_iv, exp_dv);
      end
      if (exp_iv) begin
        checks++; if (i_rdata3 !== INSN) begin errors++; $display("FAIL sweep_i_rdata cycle %0d got=%h exp=%h", k, i_rdata3, INSN); end
      end
      if (exp_dv) begin
        checks++; if (d_rdata3 !== 32'h4) begin errors++; $display("FAIL sweep_d_rdata cycle %0d got=%h exp=4", k, d_rdata3); end
      end
      nrv += int'(i_rvalid3) + int'(d_rvalid3);
      next_cycle();
    end
    checks++; if (nrv != 8) begin errors++; $display("FAIL sweep_count got=%0d exp=8", nrv); end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    int nrv;
    nrv = 0;
    i_req = 1'b1; i_addr = 32'h8;
    @(negedge clk);
    checks++; if (i_gnt3 !== 1'b1) begin errors++; $display("FAIL mid_i_gnt got=%b exp=1", i_gnt3); end
    next_cycle();
    i_req = 1'b0; d_req = 1'b1; d_addr = 32'h200; d_wen = 4'b0000;
    @(negedge clk);
    checks++; if (d_gnt3 !== 1'b1) begin errors++; $display("FAIL mid_d_gnt got=%b exp=1", d_gnt3); end
    next_cycle();
    d_req = 1'b0; i_req = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (i_gnt3 !== 1'b0 || d_gnt3 !== 1'b0 || m_en3 !== 1'b0 || m_wen3 !== 4'b0) begin
      errors++; $display("FAIL mid_rst_issue got gnt=%b%b en=%b wen=%h exp 00/0/0", i_gnt3, d_gnt3, m_en3, m_wen3);
    end
    checks++; if (i_rvalid3 !== 1'b0 || d_rvalid3 !== 1'b0) begin
      errors++; $display("FAIL mid_rst_rvalid got i=%b d=%b exp 0/0", i_rvalid3, d_rvalid3);
    end
    checks++; if (i_rdata3 !== 32'h0 || d_rdata3 !== 32'h0) begin
      errors++; $display("FAIL mid_rst_rdata got i=%h d=%h exp 0/0", i_rdata3, d_rdata3);
    end
    i_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nrv += int'(i_rvalid3) + int'(d_rvalid3);
      next_cycle();
    end
    checks++; if (nrv != 0) begin errors++; $display("FAIL mid_no_stale_rvalid got=%0d exp=0", nrv); end
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wen = 4'b0000;
    test_reset();
    test_single_fetch();
    test_priority();
    test_store_load();
    test_out_of_range();
    test_latency_sweep();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the CPU fetch port and the CPU load/store port.
- Sits between cpu_top's i_mem_*/d_mem_* buses and the memory macro or bench model.
- Arbitrates each cycle, issues at most one access, and tracks in-flight reads so read data returns to the correct requester after the fixed memory latency.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- MEM_WORDS, 1024, memory depth in 32-bit words; valid byte addresses are 0 .. 4*MEM_WORDS-1.
- RD_LATENCY, 1, cycles from m_en (read) to valid m_rdata; legal 1..4.
- STARVE_LIMIT, 4, consecutive cycles a pending fetch may lose before it is forced to win.

Ports:
- clk  in  1  system clock (all logic on posedge)
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  32  fetch byte address (word aligned)
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  i_rdata valid this cycle
- i_rdata  out  32  fetched instruction
- d_req  in  1  data request; held with d_addr/d_wdata/d_wen stable until d_gnt
- d_addr  in  32  data byte address (word aligned)
- d_wdata  in  32  store data
- d_wen  in  4  byte write enables; 4'b0000 = read
- d_gnt  out  1  data access accepted; for stores, also completion
- d_rvalid  out  1  d_rdata valid (loads only)
- d_rdata  out  32  load data
- m_en  out  1  memory access strobe
- m_addr  out  32  word index (byte address >> 2)
- m_wdata  out  32  memory write data
- m_wen  out  4  memory byte enables
- m_rdata  in  32  memory read data, RD_LATENCY cycles after a read strobe

Behaviour:
- Reset (rst_n low, async): i_gnt, d_gnt, i_rvalid, d_rvalid, m_en = 0; m_wen = 0; rdata outputs 0; starve counter 0; tag pipeline all NONE. Grants stay 0 while rst_n is low.
- Arbitration is combinational from registered state; exactly one grant at most per cycle.
  - Only one requester active: that requester wins.
  - Both active: d wins unless starve_cnt == STARVE_LIMIT, in which case i wins.
- Starve counter:
  - Increments when i_req=1 and i_gnt=0; saturates at STARVE_LIMIT.
  - Clears on i_gnt or when i_req=0.
- Issue, same cycle as the grant:
  - m_en=1; m_addr=addr[31:2]; m_wen = d_wen for a data winner, 0 for fetch; m_wdata = d_wdata.
  - m_en=0 when nobody is granted; m_wen=0 whenever m_en=0.
- Out-of-range address (addr >= 4*MEM_WORDS):
  - The request is still granted, but m_en stays 0 and out-of-range stores are dropped.
  - Out-of-range reads still produce rvalid at the normal latency, with rdata 32'hdeadbeef (fetch) or 32'hxxxxxxxx (load, i.e. undefined).
- Response tracking:
  - RD_LATENCY-deep shift register of tags {NONE, I, I_OOR, D, D_OOR}; the tag is pushed on every cycle, NONE for no-read.
  - The tag at the output stage selects the target: drives i_rvalid or d_rvalid for exactly one cycle, with the matching rdata routed from m_rdata (or the OOR constant).
  - Non-selected rdata holds its last value.
- Throughput:
  - Back-to-back grants are allowed every cycle.
  - Responses return in issue order, one per cycle maximum.
  - No backpressure on responses; requesters must accept rvalid.
- Simultaneous grant and response in the same cycle are independent and both occur.
- Reset mid-operation: the in-flight tag pipeline is cleared asynchronously; no rvalid is produced for reads issued before reset.

Decomposition:
- Package mem_arb_pkg:
  - tag enumeration (TAG_NONE, TAG_I, TAG_I_OOR, TAG_D, TAG_D_OOR)
  - BAD_INSTR = 32'hdeadbeef
  - WEN_READ = 4'b0000
- One sub-module: resp_tag_pipe (parameterised-depth tag shift register with async clear).
- Arbitration, starve counter and address decode live in the top.

Test Plan:
- Single fetch: i_req, i_addr=0x8, RD_LATENCY=1, memory word 2 = 0x00500093 -> i_gnt and m_en in cycle 0, m_addr=2; i_rvalid=1 with i_rdata=0x00500093 in cycle 1; d_rvalid stays 0.
- Priority and starvation: i_req and d_req held high continuously, d reads, STARVE_LIMIT=4 -> d_gnt for 4 cycles, i_gnt on the 5th, then the pattern repeats; responses are tagged to the correct ports in order.
- Store then load: d_wen=4'b1111, d_addr=0x200, d_wdata=4 (one cycle), then d_wen=0 at 0x200 -> m_wen=1111 and m_addr=0x80; d_gnt each cycle; d_rvalid after RD_LATENCY with d_rdata=4.
- Out of range: fetch at i_addr=0x1000 with MEM_WORDS=1024 -> i_gnt=1 and m_en=0; i_rvalid after RD_LATENCY with i_rdata=0xdeadbeef. Store at 0x1000 -> m_en=0 and memory unchanged.
- Latency sweep: RD_LATENCY=3, alternating fetch/load issued every cycle for 8 cycles -> 8 rvalids, each exactly 3 cycles after its grant, all on the correct port.
- Reset mid-flight: RD_LATENCY=3, issue 2 reads, assert rst_n low for one cycle after the second grant -> all outputs are 0 immediately and no rvalid appears after release.
